// File: rtl/asip_pipe_pkg.sv
// Shared types and constants for the ASIP pipeline-stage registers.
package asip_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int STALL_CNT_W = 16;

  localparam int PIPE_N_DEF  = 32;
  localparam int PIPE_V_DEF  = 20;
  localparam int PIPE_S_DEF  = 2;
  localparam int PIPE_CW_DEF = 16;

  // Control-bundle field offsets, shared with the decoder.
  localparam int CTRL_RF_WE_BIT  = 0;
  localparam int CTRL_MEM_WE_BIT = 1;
  localparam int CTRL_ALU_LSB    = 2;
  localparam int CTRL_ALU_W      = 4;
  localparam int CTRL_A3_LSB     = 6;
  localparam int CTRL_A3_W       = 5;

  function automatic int payload_w(input int cw, input int s, input int v, input int n);
    return cw + s * n + s * v * n;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous reset to zero.
module pipe_payload_reg
  import asip_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register with flush and back-pressure counter.
// Build option: PIPE_STAGE_SKID_EN adds a skid entry so ready_o is registered.
module pipe_stage_hs
  import asip_pipe_pkg::*;
#(
  parameter int N  = PIPE_N_DEF,
  parameter int V  = PIPE_V_DEF,
  parameter int S  = PIPE_S_DEF,
  parameter int CW = PIPE_CW_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [CW-1:0]                 ctrl_i,
  input  logic [S-1:0][N-1:0]           sdata_i,
  input  logic [S-1:0][V-1:0][N-1:0]    vdata_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [CW-1:0]                 ctrl_o,
  output logic [S-1:0][N-1:0]           sdata_o,
  output logic [S-1:0][V-1:0][N-1:0]    vdata_o,
  output logic [STALL_CNT_W-1:0]        stall_cnt_o,
  output pipe_state_e                   dbg_state_o
);

  localparam int PW = payload_w(CW, S, V, N);
  localparam int SW = S * N;
  localparam int VW = S * V * N;

  // Handshake: an entry moves across a port in a cycle where valid and ready
  // are both high at the clock edge; a valid entry is held until it moves.
  pipe_state_e            state;
  logic                   valid_q;
  logic                   xfer_in;
  logic                   xfer_out;
  logic                   main_load;
  logic [PW-1:0]          in_pl;
  logic [PW-1:0]          main_d;
  logic [PW-1:0]          main_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign in_pl    = {ctrl_i, sdata_i, vdata_i};
  assign xfer_in  = valid_i && ready_o && !flush_i;
  assign xfer_out = valid_q && ready_i;

`ifdef PIPE_STAGE_SKID_EN
  logic          ready_q;
  logic          skid_load;
  logic [PW-1:0] skid_q;

  assign ready_o   = ready_q;
  assign skid_load = (state == FULL) && xfer_in && !xfer_out;
  assign main_load = !flush_i && (((state == EMPTY) && xfer_in) ||
                                  ((state == FULL) && xfer_in && xfer_out) ||
                                  ((state == SKID) && xfer_out));
  assign main_d    = (state == SKID) ? skid_q : in_pl;

  pipe_payload_reg #(.W(PW)) u_skid (
    .CLK  (CLK),
    .RST  (RST),
    .load (skid_load),
    .d    (in_pl),
    .q    (skid_q)
  );
`else
  assign ready_o   = !valid_q || ready_i;
  assign main_load = xfer_in;
  assign main_d    = in_pl;
`endif

  pipe_payload_reg #(.W(PW)) u_main (
    .CLK  (CLK),
    .RST  (RST),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q <= 1'b1;
`endif
    end else if (flush_i) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q <= 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            state   <= FULL;
            valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (xfer_out && !xfer_in) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (xfer_in && !xfer_out) begin
            state   <= SKID;
            ready_q <= 1'b0;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (xfer_out) begin
            state   <= FULL;
            ready_q <= 1'b1;
          end
        end
`endif
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (valid_q && !ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Bubbles carry an all-zero control bundle so downstream enables stay inert.
  assign valid_o     = valid_q;
  assign ctrl_o      = valid_q ? main_q[PW-1 -: CW] : '0;
  assign sdata_o     = main_q[VW +: SW];
  assign vdata_o     = main_q[VW-1:0];
  assign stall_cnt_o = stall_cnt;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs (default or skid build).
module tb_pipe_stage_hs;
  import asip_pipe_pkg::*;

  localparam int N  = 32;
  localparam int V  = 20;
  localparam int S  = 2;
  localparam int CW = 16;

  logic                       CLK;
  logic                       RST;
  logic                       flush_i;
  logic                       valid_i;
  logic                       ready_o;
  logic [CW-1:0]              ctrl_i;
  logic [S-1:0][N-1:0]        sdata_i;
  logic [S-1:0][V-1:0][N-1:0] vdata_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [CW-1:0]              ctrl_o;
  logic [S-1:0][N-1:0]        sdata_o;
  logic [S-1:0][V-1:0][N-1:0] vdata_o;
  logic [15:0]                stall_cnt_o;
  pipe_state_e                dbg_state_o;

  int total;
  int bad;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] src_q[$];

  pipe_stage_hs #(.N(N), .V(V), .S(S), .CW(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .sdata_i     (sdata_i),
    .vdata_i     (vdata_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .sdata_o     (sdata_o),
    .vdata_o     (vdata_o),
    .stall_cnt_o (stall_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Payload fields are derived from the control word so any slice can be predicted.
  task automatic drive(input logic v, input logic [CW-1:0] c);
    valid_i    = v;
    ctrl_i     = c;
    sdata_i[0] = 32'h1000 + 32'(c);
    sdata_i[1] = 32'h2000 + 32'(c);
    for (int s = 0; s < S; s++)
      for (int l = 0; l < V; l++)
        vdata_i[s][l] = {c, 8'(l), 8'(s)};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Source holds each entry until accepted; scoreboard checks order on every out-transfer.
  task automatic bp_flow(input int cycles, input logic [31:0] rdy_mask);
    logic [CW-1:0] e;
    for (int t = 0; t < cycles; t++) begin
      if (src_q.size() > 0) drive(1'b1, src_q[0]);
      else drive(1'b0, '0);
      ready_i = rdy_mask[t];
      @(negedge CLK);
      if (t == 2) begin
        chk("bp_ready_low", 64'(ready_o), 64'd0);
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_state_skid", 64'(dbg_state_o), 64'(SKID));
`else
        chk("bp_state_full", 64'(dbg_state_o), 64'(FULL));
`endif
      end
      if (valid_o && ready_i) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
        chk("bp_order", 64'(ctrl_o), 64'(e));
        chk("bp_sdata", 64'(sdata_o[0]), 64'(32'h1000 + 32'(e)));
      end
      if (valid_i && ready_o) void'(src_q.pop_front());
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset with random inputs
    RST     = 1'b1;
    flush_i = 1'($urandom_range(0, 1));
    ready_i = 1'($urandom_range(0, 1));
    valid_i = 1'($urandom_range(0, 1));
    ctrl_i  = 16'($urandom_range(0, 16'hFFFF));
    for (int s = 0; s < S; s++) begin
      sdata_i[s] = $urandom;
      for (int l = 0; l < V; l++) vdata_i[s][l] = $urandom;
    end
    repeat (3) step();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_ctrl", 64'(ctrl_o), 64'd0);
    chk("rst_sdata", 64'({sdata_o[1], sdata_o[0]}), 64'd0);
    chk("rst_vdata", 64'(vdata_o[1][19]), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'(EMPTY));

    RST     = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, '0);
    step();
    chk("rel_ready", 64'(ready_o), 64'd1);
    chk("rel_valid", 64'(valid_o), 64'd0);

    // streaming 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i));
      step();
      chk("str_valid", 64'(valid_o), 64'd1);
      chk("str_ctrl", 64'(ctrl_o), 64'(i));
      chk("str_vdata", 64'(vdata_o[1][19]), 64'({16'(i), 8'd19, 8'd1}));
    end
    drive(1'b0, '0);
    step();
    chk("str_end_valid", 64'(valid_o), 64'd0);
    chk("str_bubble_ctrl", 64'(ctrl_o), 64'd0);
    chk("str_stall", 64'(stall_cnt_o), 64'd0);

    // back-pressure: A, B, C with ready_i low for three cycles
    src_q = '{16'h00A1, 16'h00B2, 16'h00C3};
    exp_q = '{16'h00A1, 16'h00B2, 16'h00C3};
    bp_flow(8, 32'h0000_00F1);
    chk("bp_exp_left", 64'(exp_q.size()), 64'd0);
    chk("bp_src_left", 64'(src_q.size()), 64'd0);
    chk("bp_stall", 64'(stall_cnt_o), 64'd3);
    chk("bp_end_valid", 64'(valid_o), 64'd0);

    // flush while stalled (SKID in the skid build) with a 0xDEAD entry offered
    ready_i = 1'b1;
    drive(1'b1, 16'h00C1);
    step();
    ready_i = 1'b0;
    drive(1'b1, 16'h00C2);
    step();
    drive(1'b1, 16'h0BAD);
    sdata_i[0] = 32'hDEAD;
    sdata_i[1] = 32'hDEAD;
    flush_i    = 1'b1;
    step();
    chk("fl_valid", 64'(valid_o), 64'd0);
    chk("fl_ctrl", 64'(ctrl_o), 64'd0);
    chk("fl_ready", 64'(ready_o), 64'd1);
    chk("fl_state", 64'(dbg_state_o), 64'(EMPTY));
    chk("fl_stall", 64'(stall_cnt_o), 64'd5);
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_dead", 64'((sdata_o[0] == 32'hDEAD) || (sdata_o[1] == 32'hDEAD)), 64'd0);
      chk("fl_idle_valid", 64'(valid_o), 64'd0);
    end
    drive(1'b1, 16'h00E1);
    step();
    chk("fl_next_ctrl", 64'(ctrl_o), 64'h00E1);
    chk("fl_next_sdata", 64'(sdata_o[0]), 64'h10E1);
    drive(1'b0, '0);
    step();

    // saturation of the stall counter
    drive(1'b1, 16'h0055);
    step();
    drive(1'b0, '0);
    ready_i = 1'b0;
    repeat (70000) @(posedge CLK);
    #1;
    chk("sat_cnt", 64'(stall_cnt_o), 64'hFFFF);
    step();
    step();
    chk("sat_hold", 64'(stall_cnt_o), 64'hFFFF);
    chk("sat_valid", 64'(valid_o), 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("sat_flush_cnt", 64'(stall_cnt_o), 64'hFFFF);
    chk("sat_flush_valid", 64'(valid_o), 64'd0);
    RST = 1'b1;
    #1;
    chk("sat_rst_cnt", 64'(stall_cnt_o), 64'd0);
    #1;
    RST = 1'b0;
    step();

    // asynchronous reset between edges while FULL
    ready_i = 1'b1;
    drive(1'b1, 16'h00F1);
    step();
    chk("ar_full_valid", 64'(valid_o), 64'd1);
    drive(1'b0, '0);
    ready_i = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("ar_valid", 64'(valid_o), 64'd0);
    chk("ar_ctrl", 64'(ctrl_o), 64'd0);
    chk("ar_state", 64'(dbg_state_o), 64'(EMPTY));
    chk("ar_ready", 64'(ready_o), 64'd1);
    #1;
    RST     = 1'b0;
    ready_i = 1'b1;
    drive(1'b1, 16'h00F2);
    step();
    chk("ar_first_valid", 64'(valid_o), 64'd1);
    chk("ar_first_ctrl", 64'(ctrl_o), 64'h00F2);
    chk("ar_first_sdata", 64'(sdata_o[1]), 64'h20F2);
    chk("ar_first_vdata", 64'(vdata_o[1][19]), 64'({16'h00F2, 8'd19, 8'd1}));
    drive(1'b0, '0);
    step();
    chk("ar_drain_valid", 64'(valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
